nonce_rx_fifo: RTL and testbench

NONCE_RX_FIFO -- requirements
Module: nonce_rx_fifo

---
 rtl/nonce_rx_pkg.sv | 12 +
 rtl/nonce_fifo.sv | 56 +++++
 rtl/uart_receiver.sv | 79 +++++++
 rtl/nonce_rx_fifo.sv | 116 +++++++++++
 tb/tb_nonce_rx_fifo.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/nonce_rx_pkg.sv
// Shared types for the nonce receive path: assembler state
// encoding and the default comm clock frequency.
package nonce_rx_pkg;

   localparam int unsigned DEFAULT_COMM_CLK_FREQUENCY = 100_000_000;

   typedef enum logic {
      ASM_IDLE     = 1'b0,
      ASM_ASSEMBLE = 1'b1
   } asm_state_t;

endpackage

// File: rtl/nonce_fifo.sv
// First-word-fall-through word FIFO; a push into a full FIFO is
// accepted only when a pop frees a slot the same cycle.
module nonce_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop_req,
   output logic [WIDTH-1:0]         head,
   output logic                     valid,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             full;
   logic             pop;
   logic             push_ok;

   assign valid   = (count != '0);
   assign full    = (count == CW'(DEPTH));
   assign pop     = valid & pop_req;
   assign push_ok = push & (~full | pop);
   assign head    = valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         overflow <= push & ~push_ok;
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         unique case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: mid-bit sampling off a 2-flop synchronised
// line, one-cycle tx_new_byte strobe with tx_byte on a valid stop bit.
module uart_receiver #(
   parameter int COMM_CLK_FREQUENCY = 100_000_000,
   parameter int BAUD_RATE          = 115_200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       RxD,
   output logic       tx_new_byte,
   output logic [7:0] tx_byte
);

   localparam int DIV = COMM_CLK_FREQUENCY / BAUD_RATE;
   localparam int CW  = $clog2(DIV + 1);

   typedef enum logic [1:0] {
      RX_IDLE, RX_START, RX_DATA, RX_STOP
   } rx_state_t;

   rx_state_t     state;
   logic [1:0]    sync;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          rxd_s;

   assign rxd_s = sync[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= RX_IDLE;
         sync        <= 2'b11;
         cnt         <= '0;
         bit_idx     <= '0;
         shreg       <= '0;
         tx_new_byte <= 1'b0;
         tx_byte     <= '0;
      end else begin
         sync        <= {sync[0], RxD};
         tx_new_byte <= 1'b0;
         cnt         <= cnt + 1'b1;
         unique case (state)
            RX_IDLE: begin
               cnt <= '0;
               if (!rxd_s) state <= RX_START;
            end
            RX_START: begin
               // re-check half a bit in to reject glitches
               if (cnt == CW'(DIV / 2 - 1)) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  state   <= rxd_s ? RX_IDLE : RX_DATA;
               end
            end
            RX_DATA: begin
               if (cnt == CW'(DIV - 1)) begin
                  cnt     <= '0;
                  shreg   <= {rxd_s, shreg[7:1]};
                  bit_idx <= bit_idx + 1'b1;
                  if (bit_idx == 3'd7) state <= RX_STOP;
               end
            end
            RX_STOP: begin
               if (cnt == CW'(DIV - 1)) begin
                  cnt   <= '0;
                  state <= RX_IDLE;
                  if (rxd_s) begin
                     tx_new_byte <= 1'b1;
                     tx_byte     <= shreg;
                  end
               end
            end
            default: state <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/nonce_rx_fifo.sv
// Assembles UART bytes into WORD_BYTES-wide nonces with an
// inter-byte timeout and queues them in a FWFT FIFO.
module nonce_rx_fifo
   import nonce_rx_pkg::*;
#(
   parameter int COMM_CLK_FREQUENCY = DEFAULT_COMM_CLK_FREQUENCY,
   parameter int WORD_BYTES         = 4,
   parameter int MSB_FIRST          = 1,
   parameter int FIFO_DEPTH         = 4,
   parameter int TIMEOUT_CYCLES     = 100_000
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          RxD,
   output logic [8*WORD_BYTES-1:0]       nonce,
   output logic                          new_nonce,
   input  logic                          nonce_ack,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow,
   output logic                          frame_timeout
);

   localparam int W   = 8 * WORD_BYTES;
   localparam int BCW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
   localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

   logic           rx_new;
   logic [7:0]     rx_byte;
   logic           rx_strobe;
   asm_state_t     state;
   logic [BCW-1:0] byte_cnt;
   logic [TCW-1:0] idle_cnt;
   logic [W-1:0]   asm_word;
   logic           last_byte;
   logic           timeout_hit;

   uart_receiver #(
      .COMM_CLK_FREQUENCY(COMM_CLK_FREQUENCY)
   ) u_rx (
      .clk        (clk),
      .rst        (reset),
      .RxD        (RxD),
      .tx_new_byte(rx_new),
      .tx_byte    (rx_byte)
   );

   assign rx_strobe   = rx_new & ~reset;
   assign last_byte   = rx_strobe &&
                        (byte_cnt == BCW'(WORD_BYTES - 1));
   assign timeout_hit = (state == ASM_ASSEMBLE) && !rx_strobe &&
                        (idle_cnt == TCW'(TIMEOUT_CYCLES - 1));

   generate
      if (WORD_BYTES == 1) begin : g_one
         assign asm_word = rx_byte;
      end else begin : g_multi
         logic [W-9:0] shreg;
         if (MSB_FIRST != 0) begin : g_msb
            assign asm_word = {shreg, rx_byte};
         end else begin : g_lsb
            assign asm_word = {rx_byte, shreg};
         end
         // stale bytes of a dropped word are shifted out by the next one
         always_ff @(posedge clk or posedge reset) begin
            if (reset)
               shreg <= '0;
            else if (rx_strobe)
               shreg <= (MSB_FIRST != 0) ? asm_word[W-9:0]
                                         : asm_word[W-1:8];
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= ASM_IDLE;
         byte_cnt      <= '0;
         idle_cnt      <= '0;
         frame_timeout <= 1'b0;
      end else begin
         frame_timeout <= timeout_hit;
         if (rx_strobe) begin
            idle_cnt <= '0;
            if (last_byte) begin
               state    <= ASM_IDLE;
               byte_cnt <= '0;
            end else begin
               state    <= ASM_ASSEMBLE;
               byte_cnt <= byte_cnt + 1'b1;
            end
         end else if (timeout_hit) begin
            state    <= ASM_IDLE;
            byte_cnt <= '0;
            idle_cnt <= '0;
         end else if (state == ASM_ASSEMBLE) begin
            idle_cnt <= idle_cnt + 1'b1;
         end
      end
   end

   nonce_fifo #(
      .WIDTH(W),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (last_byte),
      .push_data(asm_word),
      .pop_req  (nonce_ack),
      .head     (nonce),
      .valid    (new_nonce),
      .count    (fifo_count),
      .overflow (overflow)
   );

endmodule

// File: tb/tb_nonce_rx_fifo.sv
// Bench for nonce_rx_fifo: serial byte stimulus into an MSB-first and
// an LSB-first instance, checked against a queue model of the word FIFO.
module tb_nonce_rx_fifo;

   localparam int CLK_HZ = 921_600;
   localparam int DIV    = 8;
   localparam int TMO    = 300;
   localparam int DEPTH  = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        RxD = 1'b1;
   logic        nonce_ack = 1'b0;

   logic [31:0] nonce, nonce_l;
   logic        new_nonce, new_nonce_l;
   logic [2:0]  fifo_count, fifo_count_l;
   logic        overflow, overflow_l;
   logic        frame_timeout, frame_timeout_l;

   nonce_rx_fifo #(
      .COMM_CLK_FREQUENCY(CLK_HZ), .WORD_BYTES(4), .MSB_FIRST(1),
      .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .reset(reset), .RxD(RxD), .nonce(nonce),
      .new_nonce(new_nonce), .nonce_ack(nonce_ack),
      .fifo_count(fifo_count), .overflow(overflow),
      .frame_timeout(frame_timeout)
   );

   nonce_rx_fifo #(
      .COMM_CLK_FREQUENCY(CLK_HZ), .WORD_BYTES(4), .MSB_FIRST(0),
      .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
   ) dut_lsb (
      .clk(clk), .reset(reset), .RxD(RxD), .nonce(nonce_l),
      .new_nonce(new_nonce_l), .nonce_ack(nonce_ack),
      .fifo_count(fifo_count_l), .overflow(overflow_l),
      .frame_timeout(frame_timeout_l)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int to_cnt = 0;
   int ov_cnt = 0;
   int above1 = 0;
   logic [31:0] mq[$];
   logic [31:0] seen[$];

   always @(negedge clk) begin
      if (frame_timeout) to_cnt++;
      if (overflow) ov_cnt++;
      if (fifo_count > 3'd1) above1++;
      if (new_nonce && nonce_ack) seen.push_back(nonce);
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rev(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   task automatic send_byte(input logic [7:0] b);
      RxD = 1'b0;
      repeat (DIV) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         RxD = b[i];
         repeat (DIV) @(negedge clk);
      end
      RxD = 1'b1;
      repeat (DIV) @(negedge clk);
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) begin
         send_byte(w[31-8*i -: 8]);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
   endtask

   task automatic wait_strobe(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (dut.rx_strobe) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic check_head(input string tag);
      chk({tag, " count"}, 64'(fifo_count), 64'(mq.size()));
      chk({tag, " valid"}, 64'(new_nonce), 64'(mq.size() != 0));
      if (mq.size() != 0) begin
         chk({tag, " head"}, 64'(nonce), 64'(mq[0]));
         chk({tag, " head_lsb"}, 64'(nonce_l), 64'(rev(mq[0])));
      end
   endtask

   task automatic pop_one(input string tag);
      check_head(tag);
      nonce_ack = 1'b1;
      @(negedge clk);
      nonce_ack = 1'b0;
      if (mq.size() != 0) void'(mq.pop_front());
      @(negedge clk);
   endtask

   initial begin
      bit ok;
      int base_to, base_ov, base_seen, base_a1;
      logic [31:0] w;
      logic [31:0] exp_q[$];

      repeat (3) @(negedge clk);
      chk("rst new_nonce", 64'(new_nonce), 64'd0);
      chk("rst nonce", 64'(nonce), 64'd0);
      chk("rst count", 64'(fifo_count), 64'd0);
      chk("rst overflow", 64'(overflow), 64'd0);
      chk("rst timeout", 64'(frame_timeout), 64'd0);
      reset = 1'b0;
      repeat (4) @(negedge clk);

      // first word, with final-strobe latency check
      send_byte(8'h12);
      send_byte(8'h34);
      send_byte(8'h56);
      fork
         send_byte(8'h78);
         begin
            wait_strobe(ok);
            chk("last strobe seen", 64'(ok), 64'd1);
            chk("valid at strobe", 64'(new_nonce), 64'd0);
            @(negedge clk);
            chk("valid after strobe", 64'(new_nonce), 64'd1);
         end
      join
      repeat (2) @(negedge clk);
      chk("w1 msb", 64'(nonce), 64'h12345678);
      chk("w1 lsb", 64'(nonce_l), 64'h78563412);
      chk("w1 count", 64'(fifo_count), 64'd1);
      mq.push_back(32'h12345678);
      pop_one("w1 pop");
      check_head("after pop");

      // partial word discarded by timeout
      base_to = to_cnt;
      send_byte(8'($urandom));
      send_byte(8'($urandom));
      repeat (TMO + 20) @(negedge clk);
      chk("timeout pulses", 64'(to_cnt - base_to), 64'd1);
      chk("timeout count", 64'(fifo_count), 64'd0);
      send_word(32'hAABBCCDD);
      repeat (2) @(negedge clk);
      mq.push_back(32'hAABBCCDD);
      check_head("post timeout");
      repeat (TMO + 20) @(negedge clk);
      chk("no idle timeout", 64'(to_cnt - base_to), 64'd1);
      pop_one("aabb pop");

      // overflow with no pop
      base_ov = ov_cnt;
      for (int k = 0; k < 5; k++) begin
         w = $urandom;
         send_word(w);
         if (mq.size() < DEPTH) mq.push_back(w);
      end
      repeat (2) @(negedge clk);
      chk("ovf pulses", 64'(ov_cnt - base_ov), 64'd1);
      check_head("ovf full");
      for (int k = 0; k < 4; k++) pop_one("drain");
      check_head("drained");

      // full FIFO with pop on the final-byte cycle
      for (int k = 0; k < 4; k++) begin
         w = $urandom;
         send_word(w);
         mq.push_back(w);
      end
      base_ov = ov_cnt;
      w = $urandom;
      for (int i = 0; i < 3; i++) send_byte(w[31-8*i -: 8]);
      fork
         send_byte(w[7:0]);
         begin
            wait_strobe(ok);
            chk("ack strobe seen", 64'(ok), 64'd1);
            nonce_ack = 1'b1;
            @(negedge clk);
            nonce_ack = 1'b0;
         end
      join
      void'(mq.pop_front());
      mq.push_back(w);
      repeat (2) @(negedge clk);
      chk("no ovf on pop", 64'(ov_cnt - base_ov), 64'd0);
      check_head("push+pop full");

      // reset mid-word with 3 words queued
      pop_one("to three");
      chk("three queued", 64'(fifo_count), 64'd3);
      send_byte(8'($urandom));
      send_byte(8'($urandom));
      reset = 1'b1;
      #1;
      chk("async new_nonce", 64'(new_nonce), 64'd0);
      chk("async nonce", 64'(nonce), 64'd0);
      chk("async count", 64'(fifo_count), 64'd0);
      chk("async lsb count", 64'(fifo_count_l), 64'd0);
      chk("async ovf", 64'(overflow | overflow_l), 64'd0);
      chk("async tmo", 64'(frame_timeout | frame_timeout_l), 64'd0);
      @(negedge clk);
      send_byte(8'h5A);
      reset = 1'b0;
      mq.delete();
      repeat (4) @(negedge clk);
      check_head("reset cleared");
      w = $urandom;
      send_word(w);
      mq.push_back(w);
      repeat (2) @(negedge clk);
      check_head("post reset word");
      pop_one("post reset pop");

      // continuous ack, back-to-back words
      base_seen = seen.size();
      base_a1 = above1;
      nonce_ack = 1'b1;
      for (int k = 0; k < 6; k++) begin
         w = $urandom;
         exp_q.push_back(w);
         send_word(w);
      end
      repeat (4) @(negedge clk);
      nonce_ack = 1'b0;
      chk("stream words", 64'(seen.size() - base_seen), 64'd6);
      for (int k = 0; k < 6; k++)
         if (base_seen + k < seen.size())
            chk("stream order", 64'(seen[base_seen+k]), 64'(exp_q[k]));
      chk("stream count<=1", 64'(above1 - base_a1), 64'd0);
      chk("stream empty", 64'(fifo_count), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule
